// File: rtl/rf_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the register file and rf_bus_arbiter.
// The master modport is the side facing the arbiter: both masters plus the RF read port.
interface rf_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
);

  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_grant;
  logic              m0_done;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_grant;
  logic              m1_done;

  logic [DATA_W-1:0] rdata;
  logic              err;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  rf_rdata,
    output m0_grant, m0_done, m1_grant, m1_done,
    output rdata, err,
    output rf_we, rf_waddr, rf_raddr, rf_wdata
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output rf_rdata,
    input  m0_grant, m0_done, m1_grant, m1_done,
    input  rdata, err,
    input  rf_we, rf_waddr, rf_raddr, rf_wdata
  );

endinterface

// File: rtl/rf_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the single-port register file window.
// Each transaction runs IDLE -> ACC -> DONE; read data and error are registered at the end of ACC.
module rf_bus_arbiter #(
  parameter int unsigned             ADDR_W    = 16,
  parameter int unsigned             DATA_W    = 64,
  parameter logic [ADDR_W-1:0]       ADDR_BASE = 16'h0110,
  parameter int unsigned             NUM_REGS  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  rf_bus_arbiter_if.slave     bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [ADDR_W-1:0] NumRegsW = ADDR_W'(NUM_REGS);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              in_acc;
  logic              in_done;
  logic              owned;

  // Unsigned wrap makes addresses below ADDR_BASE land far above NUM_REGS.
  assign offset   = addr_q - ADDR_BASE;
  assign in_range = (offset < NumRegsW);

  assign in_acc  = (state_q == StAcc);
  assign in_done = (state_q == StDone);
  assign owned   = in_acc | in_done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          if (bus.m0_req && bus.m1_req) begin
            id_d = ~last_grant_q;
          end else begin
            id_d = bus.m1_req;
          end
          wr_d         = id_d ? bus.m1_wr    : bus.m0_wr;
          addr_d       = id_d ? bus.m1_addr  : bus.m0_addr;
          wdata_d      = id_d ? bus.m1_wdata : bus.m0_wdata;
          last_grant_d = id_d;
          state_d      = StAcc;
        end
      end
      StAcc: begin
        rdata_d = (!wr_q && in_range) ? bus.rf_rdata : '0;
        err_d   = !in_range;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // RF ports are only driven while a transaction owns the file.
  assign bus.m0_grant = owned & ~id_q;
  assign bus.m1_grant = owned & id_q;
  assign bus.m0_done  = in_done & ~id_q;
  assign bus.m1_done  = in_done & id_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign bus.rf_we    = in_acc & wr_q & in_range;
  assign bus.rf_waddr = in_acc ? addr_q : '0;
  assign bus.rf_raddr = in_acc ? addr_q : '0;
  assign bus.rf_wdata = in_acc ? wdata_q : '0;

  a_one_grant : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.m0_grant && bus.m1_grant));
  a_we_in_acc : assert property (@(posedge clk) disable iff (!reset_n)
    bus.rf_we |-> in_acc);

endmodule

// File: tb/tb_rf_bus_arbiter.sv
// Self-checking bench for rf_bus_arbiter: bench-side RF memory, shadow model and a
// scoreboard of expected done responses.
module tb_rf_bus_arbiter;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_REGS  = 10;
  localparam logic [15:0] ADDR_BASE = 16'h0110;

  typedef struct packed {
    logic        id;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [63:0] rf_mem [16] = '{default: '0};
  logic [63:0] model  [16] = '{default: '0};
  logic [15:0] roff;
  logic [15:0] woff;

  always #5 clk = ~clk;

  rf_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rf_bus_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ADDR_BASE(ADDR_BASE),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic in_win(input logic [15:0] a);
    logic [15:0] o;
    o = a - ADDR_BASE;
    return o < 16'(NUM_REGS);
  endfunction

  // Bench register file: combinational read, poisoned outside the window.
  assign roff = bus.rf_raddr - ADDR_BASE;
  assign woff = bus.rf_waddr - ADDR_BASE;
  assign bus.rf_rdata = in_win(bus.rf_raddr) ? rf_mem[roff[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clk) begin
    if (bus.rf_we) rf_mem[woff[3:0]] <= bus.rf_wdata;
  end

  task automatic set_req(input logic id, input logic req, input logic wr,
                         input logic [15:0] addr, input logic [63:0] wdata);
    if (id) begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic push_exp(input logic id, input logic wr, input logic [15:0] addr,
                          input logic [63:0] wdata);
    exp_t e;
    logic [15:0] o;
    o = addr - ADDR_BASE;
    e.id = id;
    e.rdata = '0;
    e.err = !in_win(addr);
    if (in_win(addr)) begin
      if (wr) model[o[3:0]] = wdata;
      else    e.rdata = model[o[3:0]];
    end
    sb.push_back(e);
  endtask

  task automatic check_common();
    n_vec++;
    if ((bus.m0_grant && bus.m1_grant) || (bus.m0_done && bus.m1_done) ||
        (bus.rf_we && !(bus.m0_grant || bus.m1_grant)) ||
        (bus.rf_we && (bus.m0_done || bus.m1_done))) begin
      n_err++;
      $display("FAIL exclusive: g0=%b g1=%b d0=%b d1=%b we=%b, required one owner, we only in ACC",
               bus.m0_grant, bus.m1_grant, bus.m0_done, bus.m1_done, bus.rf_we);
    end
  endtask

  // Compares a done pulse against the scoreboard head; returns 1 if a done was seen.
  task automatic check_done(output logic seen, output exp_t e);
    logic id;
    seen = bus.m0_done || bus.m1_done;
    e = '0;
    if (seen) begin
      id = bus.m1_done;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: id=%0d with empty scoreboard", id);
      end else begin
        e = sb.pop_front();
        if (id !== e.id || bus.rdata !== e.rdata || bus.err !== e.err) begin
          n_err++;
          $display("FAIL done_resp: got id=%0d rdata=%h err=%b required id=%0d rdata=%h err=%b",
                   id, bus.rdata, bus.err, e.id, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if (bus.m0_grant !== 1'b0 || bus.m1_grant !== 1'b0 || bus.m0_done !== 1'b0 ||
        bus.m1_done !== 1'b0 || bus.rdata !== '0 || bus.err !== 1'b0 || bus.rf_we !== 1'b0 ||
        bus.rf_waddr !== '0 || bus.rf_raddr !== '0 || bus.rf_wdata !== '0) begin
      n_err++;
      $display("FAIL %s: g=%b%b d=%b%b rdata=%h err=%b we=%b wa=%h ra=%h wd=%h, required all 0",
               name, bus.m0_grant, bus.m1_grant, bus.m0_done, bus.m1_done, bus.rdata, bus.err,
               bus.rf_we, bus.rf_waddr, bus.rf_raddr, bus.rf_wdata);
    end
  endtask

  // One full transaction from an idle arbiter, including latency and rdata-hold checks.
  task automatic run_txn(input logic id, input logic wr, input logic [15:0] addr,
                         input logic [63:0] wdata);
    int   we_cnt;
    int   lat;
    logic seen;
    logic got;
    exp_t e;
    exp_t held;
    we_cnt = 0;
    lat = 0;
    got = 1'b0;
    held = '0;
    set_req(id, 1'b1, wr, addr, wdata);
    push_exp(id, wr, addr, wdata);
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk); #1;
      check_common();
      if (c == 1) begin
        n_vec++;
        if ((id ? bus.m1_grant : bus.m0_grant) !== 1'b1) begin
          n_err++;
          $display("FAIL grant_acc: master %0d grant=%b, required 1", id,
                   id ? bus.m1_grant : bus.m0_grant);
        end
      end
      if (bus.rf_we) begin
        we_cnt++;
        n_vec++;
        if (bus.rf_waddr !== addr || bus.rf_wdata !== wdata) begin
          n_err++;
          $display("FAIL rf_write: waddr=%h wdata=%h, required %h %h",
                   bus.rf_waddr, bus.rf_wdata, addr, wdata);
        end
      end
      check_done(seen, e);
      if (seen) begin
        got = 1'b1;
        lat = c;
        held = e;
        set_req(id, 1'b0, 1'b0, '0, '0);
      end
    end
    n_vec++;
    if (!got || lat != 2) begin
      n_err++;
      $display("FAIL done_latency: seen=%b after %0d cycles, required 2", got, lat);
      set_req(id, 1'b0, 1'b0, '0, '0);
    end
    n_vec++;
    if (we_cnt != ((wr && in_win(addr)) ? 1 : 0)) begin
      n_err++;
      $display("FAIL we_count: %0d write cycles for addr %h, required %0d", we_cnt, addr,
               (wr && in_win(addr)) ? 1 : 0);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.m0_grant || bus.m1_grant || bus.rdata !== held.rdata || bus.err !== held.err) begin
      n_err++;
      $display("FAIL idle_hold: g=%b%b rdata=%h err=%b, required grants 0 rdata=%h err=%b",
               bus.m0_grant, bus.m1_grant, bus.rdata, bus.err, held.rdata, held.err);
    end
  endtask

  task automatic test_reset();
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_no_req");
  endtask

  task automatic test_write_read();
    run_txn(1'b0, 1'b1, 16'h0113, 64'hDEAD_BEEF_0000_0001);
    run_txn(1'b1, 1'b0, 16'h0113, '0);
  endtask

  task automatic test_back_to_back();
    int   dones;
    int   last_c;
    logic seen;
    exp_t e;
    dones = 0;
    last_c = 0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0113, '0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0110, '0);
    for (int k = 0; k < 4; k++) push_exp(k[0], 1'b0, k[0] ? 16'h0110 : 16'h0113, '0);
    for (int c = 1; c <= 20 && dones < 4; c++) begin
      @(posedge clk); #1;
      check_common();
      check_done(seen, e);
      if (seen) begin
        dones++;
        if (last_c != 0) begin
          n_vec++;
          if (c - last_c != 3) begin
            n_err++;
            $display("FAIL done_spacing: %0d cycles between dones, required 3", c - last_c);
          end
        end
        last_c = c;
        if (dones == 4) begin
          set_req(1'b0, 1'b0, 1'b0, '0, '0);
          set_req(1'b1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    n_vec++;
    if (dones != 4) begin
      n_err++;
      $display("FAIL alt_count: %0d dones, required 4", dones);
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
      sb.delete();
    end
    @(posedge clk); #1;
    check_common();
  endtask

  task automatic test_out_of_range();
    run_txn(1'b0, 1'b1, 16'h0110, 64'hA5A5_5A5A_1234_5678);
    run_txn(1'b0, 1'b1, 16'h0120, 64'h1111_2222_3333_4444);
    run_txn(1'b0, 1'b1, 16'h010F, 64'h5555_6666_7777_8888);
    run_txn(1'b1, 1'b1, 16'h011A, 64'h9999_AAAA_BBBB_CCCC);
    run_txn(1'b1, 1'b0, 16'h011A, '0);
    run_txn(1'b1, 1'b0, 16'h0110, '0);
  endtask

  task automatic test_last_reg();
    run_txn(1'b1, 1'b1, 16'h0119, 64'hFEED_FACE_CAFE_0019);
    run_txn(1'b1, 1'b0, 16'h0119, '0);
  endtask

  task automatic test_reset_in_done();
    logic seen;
    logic got;
    exp_t e;
    got = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0113, '0);
    push_exp(1'b0, 1'b0, 16'h0113, '0);
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk); #1;
      check_common();
      check_done(seen, e);
      got = seen;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL reset_done_wait: no done within bound, required done");
      sb.delete();
    end
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("reset_in_done");
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check_all_zero("reset_held");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");
    run_txn(1'b1, 1'b0, 16'h0119, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_last_reg();
    test_reset_in_done();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
